regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters: EX (ALU result) and MEM (load data).
- EX writes that lose arbitration are held in a small in-order FIFO.
- Writes to R15 are diverted to a PC-write output, because the register file holds only R0-R14.
- Provides per-read-port "pending" flags so the decode stage can stall on registers with uncommitted writes.

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_if.sv | 39 +++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 72 +++++++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared writeback constants, request type and helpers
//   REG_PC  : architectural register number that aliases the program counter
//   NUM_GPR : registers actually held in the register file (R0-R14)
//   DW_DEF  : default datapath width
package regfile_wb_arbiter_pkg;
    localparam logic [3:0] REG_PC  = 4'd15;
    localparam int         NUM_GPR = 15;
    localparam int         DW_DEF  = 32;

    typedef struct packed {
        logic [3:0]        wa;
        logic [DW_DEF-1:0] wd;
    } wb_req_t;

    function automatic logic is_pc(input logic [3:0] wa);
        return wa == REG_PC;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback arbiter bus
//   ex_*      : EX writeback request (valid/ready)
//   mem_*     : MEM writeback request (valid/ready)
//   ra1/ra2   : snooped register-file read addresses, pend1/pend2 the hazard flags
//   we3/wa3/wd3 : register-file write port, pc_we/pc_wd : PC write port
//   fifo_cnt  : EX pending-FIFO occupancy
interface regfile_wb_arbiter_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    logic                     ex_valid;
    logic                     ex_ready;
    logic [3:0]               ex_wa;
    logic [DW-1:0]            ex_wd;
    logic                     mem_valid;
    logic                     mem_ready;
    logic [3:0]               mem_wa;
    logic [DW-1:0]            mem_wd;
    logic [3:0]               ra1;
    logic [3:0]               ra2;
    logic                     pend1;
    logic                     pend2;
    logic                     we3;
    logic [3:0]               wa3;
    logic [DW-1:0]            wd3;
    logic                     pc_we;
    logic [DW-1:0]            pc_wd;
    logic [$clog2(DEPTH):0]   fifo_cnt;

    modport master (
        output ex_valid, ex_wa, ex_wd, mem_valid, mem_wa, mem_wd, ra1, ra2,
        input  ex_ready, mem_ready, pend1, pend2, we3, wa3, wd3, pc_we, pc_wd, fifo_cnt
    );

    modport slave (
        input  ex_valid, ex_wa, ex_wd, mem_valid, mem_wa, mem_wd, ra1, ra2,
        output ex_ready, mem_ready, pend1, pend2, we3, wa3, wd3, pc_we, pc_wd, fifo_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// regfile_wb_arbiter_wb_fifo: in-order FIFO of deferred EX writes
//   push_i/push_wa_i/push_wd_i : enqueue at tail
//   pop_i                      : dequeue head
//   head_wa_o/head_wd_o        : current head entry
//   tap_wa_o/tap_v_o           : per-slot address and occupancy for hazard matching
//   cnt_o                      : occupancy, 0..DEPTH
module regfile_wb_arbiter_wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DW_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [3:0]            push_wa_i,
    input  logic [DW-1:0]         push_wd_i,
    input  logic                  pop_i,
    output logic [3:0]            head_wa_o,
    output logic [DW-1:0]         head_wd_o,
    output logic [DEPTH-1:0][3:0] tap_wa_o,
    output logic [DEPTH-1:0]      tap_v_o,
    output logic [CW-1:0]         cnt_o
);
    logic [DEPTH-1:0][3:0]    wa_q;
    logic [DEPTH-1:0][DW-1:0] wd_q;
    logic [AW-1:0]            rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [AW-1:0]            off;

    always_comb begin
        rd_d  = pop_i ? rd_q + AW'(1) : rd_q;
        wr_d  = push_i ? wr_q + AW'(1) : wr_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            wa_q[wr_q] <= push_wa_i;
            wd_q[wr_q] <= push_wd_i;
        end
    end

    // A slot is live when its distance from the head (mod DEPTH) is below the count.
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_q;
            tap_v_o[i] = {1'b0, off} < cnt_q;
        end
    end

    assign tap_wa_o  = wa_q;
    assign head_wa_o = wa_q[rd_q];
    assign head_wd_o = wd_q[rd_q];
    assign cnt_o     = cnt_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between EX and MEM writeback
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : slave side of regfile_wb_arbiter_if (requests, hazard flags, write ports)
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][3:0] tap_wa;
    logic [DEPTH-1:0]      tap_v;
    logic [CW-1:0]         cnt;
    logic [3:0]            head_wa;
    logic [DW-1:0]         head_wd;
    logic                  mem_win, fifo_win, ex_win, ex_rdy, push, win_v;
    logic [3:0]            win_wa;
    logic [DW-1:0]         win_wd;
    logic                  we3_q, we3_d, pc_we_q, pc_we_d;
    logic [3:0]            wa3_q, wa3_d;
    logic [DW-1:0]         wd3_q, wd3_d, pc_wd_q, pc_wd_d;

    function automatic logic in_fifo(input logic [3:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) hit = hit | (tap_v[i] && tap_wa[i] == a);
        return hit;
    endfunction

    regfile_wb_arbiter_wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .push_wa_i (bus.ex_wa),
        .push_wd_i (bus.ex_wd),
        .pop_i     (fifo_win),
        .head_wa_o (head_wa),
        .head_wd_o (head_wd),
        .tap_wa_o  (tap_wa),
        .tap_v_o   (tap_v),
        .cnt_o     (cnt)
    );

    // MEM is held off while an older queued EX write targets the same register,
    // so the FIFO head always drains whenever MEM is not granted.
    always_comb begin
        ex_rdy   = cnt < CW'(DEPTH);
        mem_win  = bus.mem_valid && !in_fifo(bus.mem_wa);
        fifo_win = !mem_win && cnt != '0;
        ex_win   = !mem_win && cnt == '0 && bus.ex_valid;
        push     = bus.ex_valid && ex_rdy && !ex_win;
        win_v    = mem_win || fifo_win || ex_win;
        win_wa   = mem_win ? bus.mem_wa : fifo_win ? head_wa : bus.ex_wa;
        win_wd   = mem_win ? bus.mem_wd : fifo_win ? head_wd : bus.ex_wd;
        we3_d    = win_v && !is_pc(win_wa);
        pc_we_d  = win_v && is_pc(win_wa);
        wa3_d    = we3_d ? win_wa : wa3_q;
        wd3_d    = we3_d ? win_wd : wd3_q;
        pc_wd_d  = pc_we_d ? win_wd : pc_wd_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3_q   <= 1'b0;
            wa3_q   <= '0;
            wd3_q   <= '0;
            pc_we_q <= 1'b0;
            pc_wd_q <= '0;
        end else begin
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            pc_we_q <= pc_we_d;
            pc_wd_q <= pc_wd_d;
        end
    end

    // A register stays pending through its commit cycle (we3 high) as the file
    // only captures the value at the end of that cycle.
    assign bus.pend1     = bus.ra1 != REG_PC && (in_fifo(bus.ra1) || (we3_q && wa3_q == bus.ra1));
    assign bus.pend2     = bus.ra2 != REG_PC && (in_fifo(bus.ra2) || (we3_q && wa3_q == bus.ra2));
    assign bus.ex_ready  = ex_rdy;
    assign bus.mem_ready = !in_fifo(bus.mem_wa);
    assign bus.we3       = we3_q;
    assign bus.wa3       = wa3_q;
    assign bus.wd3       = wd3_q;
    assign bus.pc_we     = pc_we_q;
    assign bus.pc_wd     = pc_wd_q;
    assign bus.fifo_cnt  = cnt;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    regfile_wb_arbiter_if #(.DW(32), .DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          pc;
        logic [3:0]  wa;
        logic [31:0] wd;
    } wr_t;

    wr_t        q[$];
    wr_t        sb[$];
    wr_t        me;
    bit         last_we = 1'b0;
    logic [3:0] last_wa = '0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit queued(input logic [3:0] a);
        foreach (q[i]) if (q[i].wa == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_exp(input logic [3:0] a);
        return a != 4'd15 && (queued(a) || (last_we && last_wa == a));
    endfunction

    task automatic drive(input bit exv, input logic [3:0] exa, input logic [31:0] exd,
                         input bit mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic [3:0] r1, input logic [3:0] r2);
        bus.ex_valid  = exv;
        bus.ex_wa     = exa;
        bus.ex_wd     = exd;
        bus.mem_valid = mv;
        bus.mem_wa    = ma;
        bus.mem_wd    = md;
        bus.ra1       = r1;
        bus.ra2       = r2;
    endtask

    // One cycle: drive, check handshake/hazard outputs against the model, then
    // advance the model and queue the write expected to appear next cycle.
    task automatic cyc(input bit exv, input logic [3:0] exa, input logic [31:0] exd,
                       input bit mv, input logic [3:0] ma, input logic [31:0] md,
                       input logic [3:0] r1, input logic [3:0] r2);
        wr_t w, e;
        bit  exr, mr, exw;
        @(negedge clk);
        #1;
        drive(exv, exa, exd, mv, ma, md, r1, r2);
        #1;
        exr = q.size() < DEPTH;
        mr  = !queued(ma);
        chk("ex_ready", {31'd0, bus.ex_ready}, {31'd0, exr});
        chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, mr});
        chk("fifo_cnt", 32'(bus.fifo_cnt), q.size());
        chk("pend1", {31'd0, bus.pend1}, {31'd0, pend_exp(r1)});
        chk("pend2", {31'd0, bus.pend2}, {31'd0, pend_exp(r2)});
        w   = '{1'b0, 1'b0, 4'd0, 32'd0};
        e   = '{1'b1, exa == 4'd15, exa, exd};
        exw = 1'b0;
        if (mv && mr) w = '{1'b1, ma == 4'd15, ma, md};
        else if (q.size() > 0) w = q.pop_front();
        else if (exv) begin
            w   = e;
            exw = 1'b1;
        end
        if (exv && exr && !exw) q.push_back(e);
        last_we = w.v && !w.pc;
        last_wa = w.wa;
        sb.push_back(w);
    endtask

    task automatic idle(input int n, input logic [3:0] r1, input logic [3:0] r2);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, r1, r2);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_we3"}, {31'd0, bus.we3}, 32'd0);
        chk({tag, "_wa3"}, {28'd0, bus.wa3}, 32'd0);
        chk({tag, "_wd3"}, bus.wd3, 32'd0);
        chk({tag, "_pc_we"}, {31'd0, bus.pc_we}, 32'd0);
        chk({tag, "_pc_wd"}, bus.pc_wd, 32'd0);
        chk({tag, "_fifo_cnt"}, 32'(bus.fifo_cnt), 32'd0);
        chk({tag, "_ex_ready"}, {31'd0, bus.ex_ready}, 32'd1);
        chk({tag, "_pend1"}, {31'd0, bus.pend1}, 32'd0);
        chk({tag, "_pend2"}, {31'd0, bus.pend2}, 32'd0);
    endtask

    // Monitor: each cycle's registered write-port activity against the scoreboard.
    always @(negedge clk) begin
        if (!reset && sb.size() > 0) begin
            me = sb.pop_front();
            chk("we3", {31'd0, bus.we3}, {31'd0, me.v && !me.pc});
            chk("pc_we", {31'd0, bus.pc_we}, {31'd0, me.v && me.pc});
            if (me.v && !me.pc) begin
                chk("wa3", {28'd0, bus.wa3}, {28'd0, me.wa});
                chk("wd3", bus.wd3, me.wd);
            end
            if (me.v && me.pc) chk("pc_wd", bus.pc_wd, me.wd);
        end
    end

    initial begin
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd1, 4'd2);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state("rst0");
        reset = 1'b0;
        idle(2, 4'd0, 4'd15);

        // EX bypass
        cyc(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0, 4'd3, 4'd3);
        idle(2, 4'd3, 4'd4);

        // same-cycle collision on R2: MEM first, then EX
        cyc(1'b1, 4'd2, 32'hBB, 1'b1, 4'd2, 32'hAA, 4'd2, 4'd0);
        idle(3, 4'd2, 4'd1);

        // backpressure: MEM hogs the port while EX fills the FIFO
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 4'(i + 1), 32'h50 + i, 1'b1, 4'(i + 8), 32'h80 + i, 4'(i + 1), 4'd1);
        cyc(1'b1, 4'd5, 32'h54, 1'b0, 4'd0, 32'd0, 4'd5, 4'd4);
        cyc(1'b1, 4'd5, 32'h54, 1'b0, 4'd0, 32'd0, 4'd5, 4'd4);
        idle(6, 4'd5, 4'd1);

        // WAW guard on R5
        cyc(1'b1, 4'd5, 32'h55, 1'b1, 4'd9, 32'h99, 4'd5, 4'd9);
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hA5, 4'd5, 4'd9);
        cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hA5, 4'd5, 4'd9);
        idle(2, 4'd5, 4'd9);

        // R15 goes to the PC port and is never pending
        cyc(1'b1, 4'd15, 32'h100, 1'b0, 4'd0, 32'd0, 4'd15, 4'd15);
        idle(2, 4'd15, 4'd15);

        // randomized traffic; narrow MEM addresses provoke WAW stalls
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        idle(8, 4'd0, 4'd0);

        // reset with three writes queued
        cyc(1'b1, 4'd1, 32'h1, 1'b1, 4'd9, 32'h9, 4'd1, 4'd2);
        cyc(1'b1, 4'd2, 32'h2, 1'b1, 4'd10, 32'hA, 4'd1, 4'd2);
        cyc(1'b1, 4'd3, 32'h3, 1'b1, 4'd11, 32'hB, 4'd1, 4'd2);
        @(negedge clk);
        #1;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd1, 4'd2);
        reset = 1'b1;
        #1;
        chk_reset_state("rst_mid");
        q.delete();
        sb.delete();
        last_we = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        idle(4, 4'd1, 4'd3);

        repeat (2) @(negedge clk);
        #2;
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
